// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage. Non-memory results pass straight to writeback
// one cycle later. Legal word loads/stores are issued as a registered memory
// request and the stage waits (stalling upstream) for memAck or a timeout.
// Misaligned or contradictory (load+store) memory ops raise memErr instead.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   inValid               execute-stage result valid this cycle
//   isLoad / isStore      word load / word store
//   aluOut                byte address for memory ops, writeback value otherwise
//   storeData             store data
//   destReg / wbEnIn      writeback register index / register write enable
//   stall                 combinational hold request to upstream
//   memReq/memWe/memAddr/memWData   registered memory request
//   memAck / memRData     memory completion / read data
//   wbValid/wbReg/wbData  registered one-cycle writeback
//   memErr                registered one-cycle error pulse
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DBITS    = 32,
    parameter int REG_BITS = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inValid,
    input  logic                isLoad,
    input  logic                isStore,
    input  logic [DBITS-1:0]    aluOut,
    input  logic [DBITS-1:0]    storeData,
    input  logic [REG_BITS-1:0] destReg,
    input  logic                wbEnIn,
    output logic                stall,
    output logic                memReq,
    output logic                memWe,
    output logic [DBITS-1:0]    memAddr,
    output logic [DBITS-1:0]    memWData,
    input  logic                memAck,
    input  logic [DBITS-1:0]    memRData,
    output logic                wbValid,
    output logic [REG_BITS-1:0] wbReg,
    output logic [DBITS-1:0]    wbData,
    output logic                memErr
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DBITS-1:0]    mem_addr_q, mem_addr_d;
    logic [DBITS-1:0]    mem_wdata_q, mem_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_BITS-1:0] wb_reg_q, wb_reg_d;
    logic [DBITS-1:0]    wb_data_q, wb_data_d;
    logic                mem_err_q, mem_err_d;
    logic                is_load_q, is_load_d;
    logic [REG_BITS-1:0] ld_reg_q, ld_reg_d;

    logic                mem_op_s;
    logic                legal_s;
    logic                timeout_s;

    // Decode of the incoming instruction and the timeout condition.
    always_comb begin
        mem_op_s  = inValid & (isLoad | isStore);
        legal_s   = mem_op_s & (aluOut[1:0] == 2'b00) & ~(isLoad & isStore);
        timeout_s = (state_q == ST_WAIT) & ~memAck & (cnt_q == CNT_LAST);
    end

    // Upstream hold: raised while a legal op is accepted and while waiting;
    // released on the ack cycle and on the final (timing-out) wait cycle so the
    // held instruction retires exactly once.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_IDLE: stall = legal_s;
            ST_WAIT: stall = ~memAck & ~timeout_s;
            default: stall = 1'b0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        mem_err_d   = 1'b0;
        is_load_d   = is_load_q;
        ld_reg_d    = ld_reg_q;
        case (state_q)
            ST_IDLE: begin
                if (legal_s) begin
                    state_d     = ST_WAIT;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = isStore;
                    mem_addr_d  = aluOut;
                    mem_wdata_d = storeData;
                    is_load_d   = isLoad;
                    ld_reg_d    = destReg;
                end else if (mem_op_s) begin
                    // Illegal memory op: no request, error pulse only.
                    mem_err_d   = 1'b1;
                end else begin
                    wb_valid_d  = inValid & wbEnIn;
                    wb_data_d   = aluOut;
                    wb_reg_d    = destReg;
                end
            end
            ST_WAIT: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (memAck) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    if (is_load_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = memRData;
                        wb_reg_d   = ld_reg_q;
                    end else begin
                        wb_valid_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            mem_err_q   <= 1'b0;
            is_load_q   <= 1'b0;
            ld_reg_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            mem_err_q   <= mem_err_d;
            is_load_q   <= is_load_d;
            ld_reg_q    <= ld_reg_d;
        end
    end

    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWData = mem_wdata_q;
    assign wbValid  = wb_valid_q;
    assign wbReg    = wb_reg_q;
    assign wbData   = wb_data_q;
    assign memErr   = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int DB = 32;
    localparam int RB = 4;
    localparam int TO = 15;

    // Instruction kinds used by the stimulus.
    localparam int K_ALU    = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_BOTH   = 3;
    localparam int K_BUBBLE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inValid, isLoad, isStore, wbEnIn;
    logic [DB-1:0] aluOut, storeData, memRData;
    logic [RB-1:0] destReg;
    logic          stall, memReq, memWe, memAck, wbValid, memErr;
    logic [DB-1:0] memAddr, memWData, wbData;
    logic [RB-1:0] wbReg;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.DBITS(DB), .REG_BITS(RB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .isLoad(isLoad), .isStore(isStore),
        .aluOut(aluOut), .storeData(storeData), .destReg(destReg), .wbEnIn(wbEnIn),
        .stall(stall),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData),
        .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData), .memErr(memErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Executes one instruction, starting at a falling edge and ending at the
    // falling edge after its last clock. Expectations come from the stage's
    // transaction rules: what each instruction must produce, and when.
    // d = number of request cycles before memAck; d >= TO means never acked.
    task automatic do_instr(input int kind, input logic [31:0] a, input logic [31:0] sd,
                            input logic [3:0] dr, input logic wen, input int d);
        logic ld, st, v, legal, is_mem, done;
        logic [31:0] rd;
        v      = (kind != K_BUBBLE);
        ld     = (kind == K_LOAD) || (kind == K_BOTH);
        st     = (kind == K_STORE) || (kind == K_BOTH);
        if (kind == K_BUBBLE) begin
            ld = 1'($urandom_range(0, 1));
            st = 1'($urandom_range(0, 1));
        end
        is_mem = (kind >= K_LOAD) && (kind <= K_BOTH);
        legal  = ((kind == K_LOAD) || (kind == K_STORE)) && (a[1:0] == 2'b00);
        inValid = v; isLoad = ld; isStore = st; aluOut = a; storeData = sd;
        destReg = dr; wbEnIn = wen;
        memAck   = legal ? 1'b0 : 1'($urandom_range(0, 1)); // stray acks in IDLE must be ignored
        memRData = $urandom;
        #1 chk("stall_accept", {31'd0, stall}, {31'd0, legal});
        @(negedge clk);
        if (!legal) begin
            chk("memReq_none", {31'd0, memReq}, 32'd0);
            chk("memErr_idle", {31'd0, memErr}, {31'd0, is_mem});
            chk("wbValid_alu", {31'd0, wbValid}, {31'd0, (!is_mem) && v && wen});
            if ((!is_mem) && v && wen) begin
                chk("wbData_alu", wbData, a);
                chk("wbReg_alu", {28'd0, wbReg}, {28'd0, dr});
            end
        end else begin
            chk("memReq_issue", {31'd0, memReq}, 32'd1);
            chk("memWe_issue", {31'd0, memWe}, {31'd0, st});
            chk("memAddr_issue", memAddr, a);
            chk("memWData_issue", memWData, sd);
            chk("wbValid_issue", {31'd0, wbValid}, 32'd0);
            chk("memErr_issue", {31'd0, memErr}, 32'd0);
            done = 1'b0;
            for (int k = 0; k < TO && !done; k++) begin
                memAck   = (k == d);
                rd       = $urandom;
                memRData = rd;
                #1 chk("stall_wait", {31'd0, stall}, {31'd0, (k != d) && (k != TO - 1)});
                @(negedge clk);
                if (k == d) begin
                    chk("memReq_ackdrop", {31'd0, memReq}, 32'd0);
                    chk("memErr_ack", {31'd0, memErr}, 32'd0);
                    chk("wbValid_ack", {31'd0, wbValid}, {31'd0, ld});
                    if (ld) begin
                        chk("wbData_load", wbData, rd);
                        chk("wbReg_load", {28'd0, wbReg}, {28'd0, dr});
                    end
                    done = 1'b1;
                end else if (k == TO - 1) begin
                    chk("memReq_timeout", {31'd0, memReq}, 32'd0);
                    chk("memErr_timeout", {31'd0, memErr}, 32'd1);
                    chk("wbValid_timeout", {31'd0, wbValid}, 32'd0);
                    done = 1'b1;
                end else begin
                    chk("memReq_hold", {31'd0, memReq}, 32'd1);
                    chk("memWe_hold", {31'd0, memWe}, {31'd0, st});
                    chk("memAddr_hold", memAddr, a);
                    chk("wbValid_wait", {31'd0, wbValid}, 32'd0);
                    chk("memErr_wait", {31'd0, memErr}, 32'd0);
                end
            end
            memAck = 1'b0;
        end
    endtask

    initial begin
        int kind, r, dly;
        logic [31:0] a;
        rst_n = 1'b0;
        inValid = 1'b0; isLoad = 1'b0; isStore = 1'b0; wbEnIn = 1'b0;
        aluOut = 32'd0; storeData = 32'd0; destReg = 4'd0;
        memAck = 1'b0; memRData = 32'd0;
        #2;
        chk("rst_memReq", {31'd0, memReq}, 32'd0);
        chk("rst_memWe", {31'd0, memWe}, 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memWData", memWData, 32'd0);
        chk("rst_wbValid", {31'd0, wbValid}, 32'd0);
        chk("rst_wbReg", {28'd0, wbReg}, 32'd0);
        chk("rst_wbData", wbData, 32'd0);
        chk("rst_memErr", {31'd0, memErr}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        do_instr(K_LOAD,  32'h0000_0100, 32'h0, 4'd5, 1'b1, 0);        // load, immediate ack
        do_instr(K_STORE, 32'h0000_0040, 32'h1234_5678, 4'd2, 1'b0, 3); // store, ack after 3
        do_instr(K_LOAD,  32'h0000_0102, 32'h0, 4'd3, 1'b1, 0);        // misaligned load
        do_instr(K_BOTH,  32'h0000_0200, 32'h0, 4'd3, 1'b1, 0);        // load and store
        do_instr(K_LOAD,  32'h0000_0300, 32'h0, 4'd6, 1'b1, TO);       // never acked
        do_instr(K_LOAD,  32'h0000_0304, 32'h0, 4'd7, 1'b1, TO - 1);   // ack on timeout cycle
        do_instr(K_ALU,   32'd7, 32'h0, 4'd1, 1'b1, 0);                // ADD, LOAD, ADD
        do_instr(K_LOAD,  32'h0000_0400, 32'h0, 4'd8, 1'b1, 0);
        do_instr(K_ALU,   32'd42, 32'h0, 4'd9, 1'b1, 0);
        do_instr(K_ALU,   32'd99, 32'h0, 4'd9, 1'b0, 0);               // no register write
        do_instr(K_BUBBLE, 32'h0000_0500, 32'h0, 4'd4, 1'b1, 0);

        // Reset during WAIT: request must drop without a clock edge.
        inValid = 1'b1; isLoad = 1'b1; isStore = 1'b0; aluOut = 32'h0000_0600;
        destReg = 4'd11; wbEnIn = 1'b1; memAck = 1'b0;
        @(negedge clk);
        chk("rstwait_memReq_before", {31'd0, memReq}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait_memReq", {31'd0, memReq}, 32'd0);
        chk("rstwait_wbValid", {31'd0, wbValid}, 32'd0);
        chk("rstwait_memErr", {31'd0, memErr}, 32'd0);
        chk("rstwait_stall_idle", {31'd0, stall}, 32'd1);
        inValid = 1'b0;
        #1 chk("rstwait_stall_bubble", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_instr(K_ALU, 32'h0000_0055, 32'h0, 4'd12, 1'b1, 0);
        do_instr(K_STORE, 32'h0000_0700, 32'hCAFE_F00D, 4'd0, 1'b0, 1);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 19);
            if (r < 14)      dly = r % 5;
            else if (r < 17) dly = TO - 1;
            else             dly = TO;
            do_instr(kind, a, $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), dly);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
